// File: rtl/axi_copy_master128.sv
// Serial AXI copy engine: reads one burst of 128-bit beats into a local buffer,
// writes it back out to the destination, and repeats until the count is exhausted.
module axi_copy_master128 #(
  parameter int unsigned MAX_BURST = 16,
  parameter logic [7:0]  AXI_ID    = 8'h00
) (
  input  logic         pll_core_cpuclk,
  input  logic         pad_cpu_rst_b,
  input  logic         start,
  input  logic [39:0]  src_addr,
  input  logic [39:0]  dst_addr,
  input  logic [15:0]  num_beats,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [39:0]  araddr_m0,
  output logic [7:0]   arlen_m0,
  output logic [2:0]   arsize_m0,
  output logic [1:0]   arburst_m0,
  output logic [3:0]   arcache_m0,
  output logic [2:0]   arprot_m0,
  output logic [7:0]   arid_m0,
  output logic         arvalid_m0,
  input  logic         arready_m0,
  input  logic [127:0] rdata_m0,
  input  logic [7:0]   rid_m0,
  input  logic [1:0]   rresp_m0,
  input  logic         rlast_m0,
  input  logic         rvalid_m0,
  output logic         rready_m0,
  output logic [39:0]  awaddr_m0,
  output logic [7:0]   awlen_m0,
  output logic [2:0]   awsize_m0,
  output logic [1:0]   awburst_m0,
  output logic [3:0]   awcache_m0,
  output logic [2:0]   awprot_m0,
  output logic [7:0]   awid_m0,
  output logic         awvalid_m0,
  input  logic         awready_m0,
  output logic [127:0] wdata_m0,
  output logic [15:0]  wstrb_m0,
  output logic [7:0]   wid_m0,
  output logic         wlast_m0,
  output logic         wvalid_m0,
  input  logic         wready_m0,
  input  logic [7:0]   bid_m0,
  input  logic [1:0]   bresp_m0,
  input  logic         bvalid_m0,
  output logic         bready_m0,
  output logic [2:0]   dbg_state_o
);

  // Handshakes: a beat transfers on the rising edge where valid and ready are both 1;
  // this block never drops a valid or changes its payload before that edge.

  localparam int unsigned IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_FIN} state_e;

  state_e       state_q, state_d;
  logic [39:0]  src_q, src_d;
  logic [39:0]  dst_q, dst_d;
  logic [15:0]  rem_q, rem_d;
  logic [8:0]   blen_q, blen_d;
  logic [8:0]   cnt_q, cnt_d;
  logic         err_q, err_d;
  logic [127:0] buf_q [MAX_BURST];

  logic [8:0]   src_room, dst_room, blen_calc;
  logic [16:0]  blen_min;
  logic         rd_hs;

  // Room left before the next 4KB boundary, in beats, on each side.
  assign src_room = 9'd256 - {1'b0, src_q[11:4]};
  assign dst_room = 9'd256 - {1'b0, dst_q[11:4]};

  always_comb begin
    blen_min = {1'b0, rem_q};
    if (blen_min > 17'(MAX_BURST))     blen_min = 17'(MAX_BURST);
    if (blen_min > {8'd0, src_room})   blen_min = {8'd0, src_room};
    if (blen_min > {8'd0, dst_room})   blen_min = {8'd0, dst_room};
  end
  assign blen_calc = blen_min[8:0];

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign rd_hs = (state_q == S_R) && rvalid_m0;

  always_ff @(posedge pll_core_cpuclk) begin
    if (rd_hs) buf_q[cnt_q[IW-1:0]] <= rdata_m0;
  end

  // One counter serves both the read fill and the write drain since they never overlap.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    blen_d     = blen_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    arvalid_m0 = 1'b0;
    rready_m0  = 1'b0;
    awvalid_m0 = 1'b0;
    wvalid_m0  = 1'b0;
    bready_m0  = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_beats == 16'd0) begin
            state_d = S_FIN;
          end else begin
            src_d   = {src_addr[39:4], 4'h0};
            dst_d   = {dst_addr[39:4], 4'h0};
            rem_d   = num_beats;
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        arvalid_m0 = 1'b1;
        if (arready_m0) begin
          blen_d  = blen_calc;
          cnt_d   = 9'd0;
          state_d = S_R;
        end
      end
      S_R: begin
        rready_m0 = 1'b1;
        if (rvalid_m0) begin
          cnt_d = cnt_q + 9'd1;
          if (rresp_m0 != 2'b00) err_d = 1'b1;
          if (cnt_q == blen_q - 9'd1) state_d = S_AW;
        end
      end
      S_AW: begin
        awvalid_m0 = 1'b1;
        if (awready_m0) begin
          cnt_d   = 9'd0;
          state_d = S_W;
        end
      end
      S_W: begin
        wvalid_m0 = 1'b1;
        if (wready_m0) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == blen_q - 9'd1) state_d = S_B;
        end
      end
      S_B: begin
        bready_m0 = 1'b1;
        if (bvalid_m0) begin
          if (bresp_m0 != 2'b00) err_d = 1'b1;
          rem_d   = rem_q - 16'(blen_q);
          src_d   = src_q + {27'd0, blen_q, 4'h0};
          dst_d   = dst_q + {27'd0, blen_q, 4'h0};
          state_d = (rem_q == 16'(blen_q)) ? S_FIN : S_AR;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign dbg_state_o = state_q;

  assign araddr_m0  = src_q;
  assign arlen_m0   = 8'(blen_calc - 9'd1);
  assign arsize_m0  = 3'b100;
  assign arburst_m0 = 2'b01;
  assign arcache_m0 = 4'b0011;
  assign arprot_m0  = 3'b000;
  assign arid_m0    = AXI_ID;

  assign awaddr_m0  = dst_q;
  assign awlen_m0   = 8'(blen_q - 9'd1);
  assign awsize_m0  = 3'b100;
  assign awburst_m0 = 2'b01;
  assign awcache_m0 = 4'b0011;
  assign awprot_m0  = 3'b000;
  assign awid_m0    = AXI_ID;

  assign wdata_m0   = buf_q[cnt_q[IW-1:0]];
  assign wstrb_m0   = 16'hffff;
  assign wid_m0     = AXI_ID;
  assign wlast_m0   = (state_q == S_W) && (cnt_q == blen_q - 9'd1);

  logic unused_ok;
  assign unused_ok = ^{rid_m0, bid_m0, rlast_m0, src_addr[3:0], dst_addr[3:0], blen_min[16:9]};

endmodule

// File: tb/tb_axi_copy_master128.sv
// Bench for axi_copy_master128: a reactive AXI slave model plus a scoreboard of
// expected AR/AW/W/done events popped by an independent monitor.
module tb_axi_copy_master128;

  logic         clk, rst_n;
  logic         start;
  logic [39:0]  src_addr, dst_addr;
  logic [15:0]  num_beats;
  logic         busy, done, err;
  logic [39:0]  araddr;  logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
  logic [3:0]   arcache; logic [2:0] arprot; logic [7:0] arid; logic arvalid, arready;
  logic [127:0] rdata;   logic [7:0] rid; logic [1:0] rresp; logic rlast, rvalid, rready;
  logic [39:0]  awaddr;  logic [7:0] awlen; logic [2:0] awsize; logic [1:0] awburst;
  logic [3:0]   awcache; logic [2:0] awprot; logic [7:0] awid; logic awvalid, awready;
  logic [127:0] wdata;   logic [15:0] wstrb; logic [7:0] wid; logic wlast, wvalid, wready;
  logic [7:0]   bid;     logic [1:0] bresp; logic bvalid, bready;
  logic [2:0]   dbg_state;

  axi_copy_master128 #(.MAX_BURST(16), .AXI_ID(8'h00)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .err(err),
    .araddr_m0(araddr), .arlen_m0(arlen), .arsize_m0(arsize), .arburst_m0(arburst),
    .arcache_m0(arcache), .arprot_m0(arprot), .arid_m0(arid), .arvalid_m0(arvalid),
    .arready_m0(arready),
    .rdata_m0(rdata), .rid_m0(rid), .rresp_m0(rresp), .rlast_m0(rlast),
    .rvalid_m0(rvalid), .rready_m0(rready),
    .awaddr_m0(awaddr), .awlen_m0(awlen), .awsize_m0(awsize), .awburst_m0(awburst),
    .awcache_m0(awcache), .awprot_m0(awprot), .awid_m0(awid), .awvalid_m0(awvalid),
    .awready_m0(awready),
    .wdata_m0(wdata), .wstrb_m0(wstrb), .wid_m0(wid), .wlast_m0(wlast),
    .wvalid_m0(wvalid), .wready_m0(wready),
    .bid_m0(bid), .bresp_m0(bresp), .bvalid_m0(bvalid), .bready_m0(bready),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [47:0]  exp_ar_q[$];
  logic [47:0]  exp_aw_q[$];
  logic [128:0] exp_w_q[$];
  logic         exp_done_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    chk_cnt++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  function automatic logic [127:0] pat(input logic [39:0] a);
    return {24'h5a5a5a, a, 24'h3c3c3c, a};
  endfunction

  task automatic plan_burst(input logic [39:0] s, input logic [39:0] d, input int len);
    logic l;
    exp_ar_q.push_back({s, 8'(len - 1)});
    exp_aw_q.push_back({d, 8'(len - 1)});
    for (int k = 0; k < len; k++) begin
      l = (k == len - 1);
      exp_w_q.push_back({l, pat(s + 40'(16 * k))});
    end
  endtask

  // ---------------- slave model ----------------
  int   rd_left = 0, wr_left = 0;
  logic [39:0] rd_addr = '0;
  logic b_pending = 1'b0;
  int   ar_wait = -1, aw_wait = -1, w_wait = -1;
  logic bp = 1'b0;
  logic b_err_once = 1'b0;
  logic [1:0] rresp_cfg = 2'b00;
  int   r_hs_cnt = 0, w_hs_cnt = 0;

  initial begin
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0; rid = 8'h00;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
        rd_left = 0; wr_left = 0; b_pending = 0; ar_wait = -1; aw_wait = -1; w_wait = -1;
      end else begin
        rvalid = 0; rlast = 0;
        if (rd_left > 0) begin
          rvalid = 1; rdata = pat(rd_addr); rlast = (rd_left == 1); rresp = rresp_cfg;
          if (rready) begin rd_addr = rd_addr + 40'd16; rd_left--; r_hs_cnt++; end
        end
        arready = 0;
        if (arvalid && rd_left == 0) begin
          if (ar_wait < 0) ar_wait = bp ? int'($urandom_range(1, 5)) : 0;
          if (ar_wait == 0) begin
            arready = 1; ar_wait = -1; rd_addr = araddr; rd_left = int'(arlen) + 1;
          end else ar_wait--;
        end
        bvalid = 0;
        if (b_pending) begin
          bvalid = 1; bresp = b_err_once ? 2'b10 : 2'b00;
          if (bready) begin b_pending = 0; b_err_once = 0; end
        end
        awready = 0;
        if (awvalid && wr_left == 0 && !b_pending) begin
          if (aw_wait < 0) aw_wait = bp ? int'($urandom_range(1, 5)) : 0;
          if (aw_wait == 0) begin
            awready = 1; aw_wait = -1; wr_left = int'(awlen) + 1;
          end else aw_wait--;
        end
        wready = 0;
        if (wvalid && wr_left > 0) begin
          if (w_wait < 0) w_wait = bp ? int'($urandom_range(1, 5)) : 0;
          if (w_wait == 0) begin
            wready = 1; w_wait = -1; wr_left--; w_hs_cnt++;
            if (wr_left == 0) b_pending = 1;
          end else w_wait--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic ar_stall = 0, aw_stall = 0, w_stall = 0;
  logic [47:0]  ar_prev, aw_prev;
  logic [128:0] w_prev;

  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        ar_stall = 0; aw_stall = 0; w_stall = 0;
      end else begin
        if (ar_stall) chk("ar_hold", {arvalid, araddr, arlen}, {1'b1, ar_prev});
        if (aw_stall) chk("aw_hold", {awvalid, awaddr, awlen}, {1'b1, aw_prev});
        if (w_stall)  chk("w_hold",  {wvalid, wlast, wdata},  {1'b1, w_prev});
        ar_stall = arvalid && !arready; ar_prev = {araddr, arlen};
        aw_stall = awvalid && !awready; aw_prev = {awaddr, awlen};
        w_stall  = wvalid && !wready;   w_prev  = {wlast, wdata};
        if (arvalid && arready) begin
          if (exp_ar_q.size() == 0) note_fail("ar_extra");
          else chk("ar_burst", {araddr, arlen}, exp_ar_q.pop_front());
          chk("ar_fixed", {arsize, arburst, arcache, arprot, arid},
              {3'b100, 2'b01, 4'b0011, 3'b000, 8'h00});
        end
        if (awvalid && awready) begin
          if (exp_aw_q.size() == 0) note_fail("aw_extra");
          else chk("aw_burst", {awaddr, awlen}, exp_aw_q.pop_front());
          chk("aw_fixed", {awsize, awburst, awcache, awprot, awid},
              {3'b100, 2'b01, 4'b0011, 3'b000, 8'h00});
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() == 0) note_fail("w_extra");
          else chk("w_beat", {wlast, wdata}, exp_w_q.pop_front());
          chk("w_fixed", {wstrb, wid}, {16'hffff, 8'h00});
        end
        if (done) begin
          if (exp_done_q.size() == 0) note_fail("done_extra");
          else chk("done_err", err, exp_done_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [39:0] s, input logic [39:0] d, input logic [15:0] n);
    @(negedge clk);
    start = 1; src_addr = s; dst_addr = d; num_beats = n;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    if (!done) note_fail(name);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  task automatic run_copy(input string name, input logic [39:0] s, input logic [39:0] d,
                          input logic [15:0] n);
    pulse_start(s, d, n);
    wait_done(name);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int cyc;
    rst_n = 0; start = 0; src_addr = '0; dst_addr = '0; num_beats = '0;
    repeat (3) @(negedge clk);
    #1 chk("reset_state", {busy, done, err, arvalid, rready, awvalid, wvalid, bready}, 8'h00);
    @(negedge clk); #2 rst_n = 1;

    // single beat
    plan_burst(40'h1000, 40'h2000, 1); exp_done_q.push_back(1'b0);
    run_copy("single_timeout", 40'h1000, 40'h2000, 16'd1);

    // split into 16 + 4
    plan_burst(40'h0, 40'h8000, 16); plan_burst(40'h100, 40'h8100, 4);
    exp_done_q.push_back(1'b0);
    run_copy("split_timeout", 40'h0, 40'h8000, 16'd20);

    // 4KB boundary on the source side
    plan_burst(40'h0FE0, 40'h3000, 2); plan_burst(40'h1000, 40'h3020, 2);
    exp_done_q.push_back(1'b0);
    run_copy("4k_timeout", 40'h0FE0, 40'h3000, 16'd4);

    // backpressure on AR/AW/W
    bp = 1; w_hs_cnt = 0;
    plan_burst(40'h5000, 40'h7000, 8); exp_done_q.push_back(1'b0);
    run_copy("bp_timeout", 40'h5000, 40'h7000, 16'd8);
    bp = 0;
    chk("bp_w_count", w_hs_cnt, 8);

    // bresp error on first B is sticky through done
    b_err_once = 1;
    plan_burst(40'h9000, 40'hA000, 16); plan_burst(40'h9100, 40'hA100, 1);
    exp_done_q.push_back(1'b1);
    run_copy("berr_timeout", 40'h9000, 40'hA000, 16'd17);
    chk("err_sticky", err, 1'b1);

    // accepted start clears err
    plan_burst(40'h1010, 40'h2010, 1); exp_done_q.push_back(1'b0);
    pulse_start(40'h1010, 40'h2010, 16'd1);
    chk("err_cleared", err, 1'b0);
    wait_done("clear_timeout");

    // rresp error
    rresp_cfg = 2'b10;
    plan_burst(40'hE000, 40'hF000, 1); exp_done_q.push_back(1'b1);
    run_copy("rerr_timeout", 40'hE000, 40'hF000, 16'd1);
    rresp_cfg = 2'b00;

    // zero beats: done the cycle after start, err cleared, no traffic
    exp_done_q.push_back(1'b0);
    pulse_start(40'h4000, 40'h6000, 16'd0);
    chk("zero_done", {done, busy, err}, 3'b110);
    @(negedge clk);
    chk("zero_after", {done, busy}, 2'b00);

    // start while busy is ignored
    plan_burst(40'hB000, 40'hC000, 2); exp_done_q.push_back(1'b0);
    pulse_start(40'hB000, 40'hC000, 16'd2);
    repeat (2) @(negedge clk);
    pulse_start(40'hD000, 40'hD800, 16'd5);
    wait_done("busy_timeout");
    repeat (5) @(negedge clk);

    // reset during the third R beat
    r_hs_cnt = 0;
    exp_ar_q.push_back({40'h4000, 8'd3});
    pulse_start(40'h4000, 40'h6000, 16'd4);
    cyc = 0;
    while (r_hs_cnt < 2 && cyc < 200) begin @(negedge clk); #3; cyc++; end
    if (r_hs_cnt < 2) note_fail("rst_mid_wait");
    @(negedge clk); #2 rst_n = 0;
    #1 chk("rst_mid", {busy, done, err, arvalid, rready, awvalid, wvalid, bready}, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    repeat (3) @(negedge clk);
    plan_burst(40'h4000, 40'h6000, 4); exp_done_q.push_back(1'b0);
    run_copy("post_rst_timeout", 40'h4000, 40'h6000, 16'd4);

    repeat (10) @(negedge clk);
    chk("ar_q_empty",   exp_ar_q.size(), 0);
    chk("aw_q_empty",   exp_aw_q.size(), 0);
    chk("w_q_empty",    exp_w_q.size(), 0);
    chk("done_q_empty", exp_done_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
